avr_isp_sequencer: RTL

// Command sequencer sitting directly upstream of spi_master (SPI_WIDTH=32) in the target-programming path.

---
 rtl/isp_pkg.sv | 35 +++
 rtl/avr_isp_sequencer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/isp_pkg.sv
// Opcodes, response constants and FSM state encoding for the AVR ISP sequencer.
package isp_pkg;

  localparam logic [31:0] OP_PE      = 32'hAC53_0000;
  localparam logic [31:0] OP_ERASE   = 32'hAC80_0000;
  localparam logic [31:0] OP_POLL    = 32'hF000_0000;
  localparam logic [7:0]  OP_LOAD_LO = 8'h40;
  localparam logic [7:0]  OP_LOAD_HI = 8'h48;
  localparam logic [7:0]  OP_WRITE   = 8'h4C;
  localparam logic [7:0]  PE_ECHO    = 8'h53;

  // Every instruction is split into a _TX state (tx_valid high) and an _RX
  // state (rx_ready high), so exactly one instruction is ever outstanding.
  typedef enum logic [4:0] {
    S_IDLE,
    S_RST_HOLD,
    S_RST_PULSE,
    S_PE_TX,
    S_PE_RX,
    S_ERASE_TX,
    S_ERASE_RX,
    S_POLL_TX,
    S_POLL_RX,
    S_LOAD,
    S_LOAD_LO_TX,
    S_LOAD_LO_RX,
    S_LOAD_HI_TX,
    S_LOAD_HI_RX,
    S_WRITE_TX,
    S_WRITE_RX,
    S_FINISH,
    S_ERROR
  } state_t;

endpackage

// File: rtl/avr_isp_sequencer.sv
// AVR ISP command sequencer: turns a start pulse plus a 16-bit flash word
// stream into reset hold, programming enable, erase, page load/write and
// busy-poll instructions for a 32-bit SPI master.
module avr_isp_sequencer
  import isp_pkg::*;
#(
  parameter int unsigned PAGE_WORDS = 32,
  parameter int unsigned RST_CYCLES = 1_000_000,
  parameter int unsigned PE_TRIES   = 4,
  parameter int unsigned POLL_MAX   = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        word_valid,
  output logic        word_ready,
  input  logic [15:0] word_data,
  input  logic        word_last,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        isp_reset,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [31:0] tx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  input  logic [31:0] rx_data
);

  localparam logic [15:0] PAGE_MASK = 16'(PAGE_WORDS - 1);

  state_t      state;
  state_t      state_next;
  state_t      ret_state;
  logic [31:0] rst_cnt;
  logic [31:0] poll_cnt;
  logic [31:0] pe_try;
  logic [15:0] word_addr;
  logic [15:0] page_base;
  logic [15:0] word_lat;
  logic        last_lat;
  logic        error_q;
  logic        page_end;
  logic        unused_rx;

  // Only the echo byte and the busy bit of a response carry information.
  assign unused_rx = ^{rx_data[31:16], rx_data[7:1]};

  assign page_end = (word_addr & PAGE_MASK) == PAGE_MASK;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:       if (start) state_next = S_RST_HOLD;
      S_RST_HOLD:   if (rst_cnt == RST_CYCLES - 32'd1) state_next = S_PE_TX;
      S_RST_PULSE:  state_next = S_RST_HOLD;
      S_PE_TX:      if (tx_ready) state_next = S_PE_RX;
      S_PE_RX: begin
        if (rx_valid) begin
          if (rx_data[15:8] == PE_ECHO)       state_next = S_ERASE_TX;
          else if (pe_try + 32'd1 < PE_TRIES) state_next = S_RST_PULSE;
          else                                state_next = S_ERROR;
        end
      end
      S_ERASE_TX:   if (tx_ready) state_next = S_ERASE_RX;
      S_ERASE_RX:   if (rx_valid) state_next = S_POLL_TX;
      S_POLL_TX:    if (tx_ready) state_next = S_POLL_RX;
      S_POLL_RX: begin
        if (rx_valid) begin
          if (!rx_data[0])                      state_next = ret_state;
          else if (poll_cnt + 32'd1 >= POLL_MAX) state_next = S_ERROR;
          else                                  state_next = S_POLL_TX;
        end
      end
      S_LOAD:       if (word_valid) state_next = S_LOAD_LO_TX;
      S_LOAD_LO_TX: if (tx_ready) state_next = S_LOAD_LO_RX;
      S_LOAD_LO_RX: if (rx_valid) state_next = S_LOAD_HI_TX;
      S_LOAD_HI_TX: if (tx_ready) state_next = S_LOAD_HI_RX;
      S_LOAD_HI_RX: begin
        if (rx_valid) state_next = (page_end || last_lat) ? S_WRITE_TX : S_LOAD;
      end
      S_WRITE_TX:   if (tx_ready) state_next = S_WRITE_RX;
      S_WRITE_RX:   if (rx_valid) state_next = S_POLL_TX;
      S_FINISH:     state_next = S_IDLE;
      S_ERROR:      state_next = S_IDLE;
      default:      state_next = S_IDLE;
    endcase
  end

  // Counters, latched word, poll return target and sticky error
  always_ff @(posedge clk) begin
    if (rst) begin
      rst_cnt   <= '0;
      poll_cnt  <= '0;
      pe_try    <= '0;
      word_addr <= '0;
      page_base <= '0;
      word_lat  <= '0;
      last_lat  <= 1'b0;
      error_q   <= 1'b0;
      ret_state <= S_LOAD;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            error_q   <= 1'b0;
            word_addr <= '0;
            pe_try    <= '0;
            rst_cnt   <= '0;
            last_lat  <= 1'b0;
          end
        end
        S_RST_HOLD:  rst_cnt <= rst_cnt + 32'd1;
        S_RST_PULSE: rst_cnt <= '0;
        S_PE_RX: begin
          if (rx_valid && rx_data[15:8] != PE_ECHO) pe_try <= pe_try + 32'd1;
        end
        S_ERASE_RX: begin
          if (rx_valid) begin
            poll_cnt  <= '0;
            ret_state <= S_LOAD;
          end
        end
        S_POLL_RX: if (rx_valid) poll_cnt <= poll_cnt + 32'd1;
        S_LOAD: begin
          if (word_valid) begin
            word_lat <= word_data;
            last_lat <= word_last;
          end
        end
        S_LOAD_HI_RX: begin
          if (rx_valid) begin
            // Page base comes from the address of the word just loaded,
            // captured before the increment moves it into the next page.
            page_base <= word_addr & ~PAGE_MASK;
            word_addr <= word_addr + 16'd1;
          end
        end
        S_WRITE_RX: begin
          if (rx_valid) begin
            poll_cnt  <= '0;
            ret_state <= last_lat ? S_FINISH : S_LOAD;
          end
        end
        default: ;
      endcase
      if (state_next == S_ERROR) error_q <= 1'b1;
    end
  end

  // Output decode
  always_comb begin
    busy       = (state != S_IDLE);
    done       = (state == S_FINISH);
    error      = error_q;
    isp_reset  = !(state inside {S_IDLE, S_RST_PULSE, S_FINISH, S_ERROR});
    word_ready = (state == S_LOAD);
    tx_valid   = state inside {S_PE_TX, S_ERASE_TX, S_POLL_TX, S_LOAD_LO_TX,
                               S_LOAD_HI_TX, S_WRITE_TX};
    rx_ready   = state inside {S_PE_RX, S_ERASE_RX, S_POLL_RX, S_LOAD_LO_RX,
                               S_LOAD_HI_RX, S_WRITE_RX};
    tx_data    = '0;
    case (state)
      S_PE_TX:      tx_data = OP_PE;
      S_ERASE_TX:   tx_data = OP_ERASE;
      S_POLL_TX:    tx_data = OP_POLL;
      S_LOAD_LO_TX: tx_data = {OP_LOAD_LO, 8'h00, word_addr[7:0], word_lat[7:0]};
      S_LOAD_HI_TX: tx_data = {OP_LOAD_HI, 8'h00, word_addr[7:0], word_lat[15:8]};
      S_WRITE_TX:   tx_data = {OP_WRITE, page_base[15:8], page_base[7:0], 8'h00};
      default:      tx_data = '0;
    endcase
  end

endmodule
